// File: rtl/mem_resp.sv
// Single-port memory responder: fixed-latency reads, zero-fill after reset, backdoor load port.
// Optional MEM_RESP_STATS_EN adds saturating dut-port read/write counters (rd_cnt, wr_cnt).
module mem_resp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_REQ0,
  input  logic              mem_WE0,
  input  logic [ADDR_W-1:0] mem_A0,
  input  logic [DATA_W-1:0] mem_DIN0,
  output logic [DATA_W-1:0] mem_DOUT0,
  input  logic              init_vld,
  output logic              init_busy,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  output logic              clear_done,
  output logic              err
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
`endif
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH-1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              a_ok, init_ok, clr_we, dut_wr, bd_wr, rd_req, err_set;
  logic [DATA_W-1:0] rd_word;
  logic              rd_vld_p  [RD_LAT];
  logic [DATA_W-1:0] rd_data_p [RD_LAT];
  logic [DATA_W-1:0] dout_hold;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

`ifdef MEM_RESP_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) ptr <= ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    init_busy = 1'b1;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (ptr == PTR_LAST) state_nxt = RUN;
      end
      RUN:     init_busy = mem_REQ0;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    a_ok    = in_range(mem_A0);
    init_ok = in_range(init_addr);
    dut_wr  = (state == RUN) && mem_REQ0 && mem_WE0 && a_ok;
    bd_wr   = init_vld && !init_busy && init_ok;
    rd_req  = mem_REQ0 && !mem_WE0;
    rd_word = (state == RUN && a_ok) ? mem[mem_A0] : '0;
    err_set = 1'b0;
    if (mem_REQ0 && (state == CLEAR || !a_ok)) err_set = 1'b1;
    if (init_vld && !init_busy && !init_ok)    err_set = 1'b1;
  end

  // Storage: one write per cycle; the dut port owns it in RUN, backdoor only when idle.
  always_ff @(posedge clk) begin
    if (clr_we)      mem[ptr]       <= '0;
    else if (dut_wr) mem[mem_A0]    <= mem_DIN0;
    else if (bd_wr)  mem[init_addr] <= init_data;
  end

  // Stage p0..p(RD_LAT-1): read valid and data travel together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) rd_vld_p[i] <= 1'b0;
      dout_hold <= '0;
    end else begin
      rd_vld_p[0] <= rd_req;
      for (int i = 1; i < RD_LAT; i++) rd_vld_p[i] <= rd_vld_p[i-1];
      if (rd_vld_p[RD_LAT-1]) dout_hold <= rd_data_p[RD_LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    rd_data_p[0] <= rd_word;
    for (int i = 1; i < RD_LAT; i++) rd_data_p[i] <= rd_data_p[i-1];
  end

  // Output stage: the final stage drives DOUT in its own cycle, then the hold register keeps it.
  assign mem_DOUT0 = rd_vld_p[RD_LAT-1] ? rd_data_p[RD_LAT-1] : dout_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      clear_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (state == CLEAR && state_nxt == RUN) clear_done <= 1'b1;
      if (err_set) err <= 1'b1;
    end
  end

`ifdef MEM_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (state == RUN && mem_REQ0) begin
      if (mem_WE0) wr_cnt <= sat_inc(wr_cnt);
      else         rd_cnt <= sat_inc(rd_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp (DEPTH=48, RD_LAT=2): vector table plus multi-cycle sequences.
module tb_mem_resp;

  localparam int DW  = 8;
  localparam int AW  = 6;
  localparam int DEP = 48;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_REQ0, mem_WE0;
  logic [AW-1:0] mem_A0;
  logic [DW-1:0] mem_DIN0, mem_DOUT0;
  logic          init_vld, init_busy;
  logic [AW-1:0] init_addr;
  logic [DW-1:0] init_data;
  logic          clear_done, err;
`ifdef MEM_RESP_STATS_EN
  logic [15:0]   rd_cnt, wr_cnt;
`endif

  mem_resp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .mem_REQ0(mem_REQ0), .mem_WE0(mem_WE0), .mem_A0(mem_A0),
    .mem_DIN0(mem_DIN0), .mem_DOUT0(mem_DOUT0),
    .init_vld(init_vld), .init_busy(init_busy),
    .init_addr(init_addr), .init_data(init_data),
    .clear_done(clear_done), .err(err)
`ifdef MEM_RESP_STATS_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          req;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          iv;
    logic [AW-1:0] ia;
    logic [DW-1:0] id;
    logic [DW-1:0] exp_dout;
    logic          exp_busy;
  } vec_t;

  vec_t vecs [16];
  int   tests = 0;
  int   fails = 0;
  int   exp_rd = 0;
  int   exp_wr = 0;
  logic in_run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then sit at the falling edge.
  task automatic step(input logic req, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic iv, input logic [AW-1:0] ia,
                      input logic [DW-1:0] id);
    @(posedge clk); #1;
    mem_REQ0 = req; mem_WE0 = we; mem_A0 = a; mem_DIN0 = d;
    init_vld = iv; init_addr = ia; init_data = id;
    if (in_run && req) begin
      if (we) exp_wr++;
      else    exp_rd++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_clear(output int n, output logic early);
    n = 0;
    early = 1'b0;
    while (init_busy === 1'b1 && n < 200) begin
      if (clear_done !== 1'b0) early = 1'b1;
      n++;
      idle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic early;

    vecs[0]  = '{1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 6'd3, 8'h5A, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 6'd3,  8'h00, 1'b0, 6'd0, 8'h00, 8'h00, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 6'd7,  8'h11, 1'b0, 6'd0, 8'h00, 8'h00, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 6'd7,  8'h00, 1'b0, 6'd0, 8'h00, 8'h5A, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 6'd8,  8'h00, 1'b0, 6'd0, 8'h00, 8'h5A, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 6'd3,  8'h00, 1'b0, 6'd0, 8'h00, 8'h11, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 6'd0,  8'h00, 1'b0, 6'd0, 8'h00, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 6'd0,  8'h00, 1'b0, 6'd0, 8'h00, 8'h5A, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 6'd0,  8'h00, 1'b0, 6'd0, 8'h00, 8'h5A, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 6'd0,  8'hC3, 1'b1, 6'd9, 8'h77, 8'h5A, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 6'd0,  8'h00, 1'b0, 6'd0, 8'h00, 8'h5A, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 6'd47, 8'hA5, 1'b0, 6'd0, 8'h00, 8'h5A, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 6'd47, 8'h00, 1'b0, 6'd0, 8'h00, 8'hC3, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 6'd9,  8'h00, 1'b0, 6'd0, 8'h00, 8'hC3, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 6'd0,  8'h00, 1'b0, 6'd0, 8'h00, 8'hA5, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 6'd0,  8'h00, 1'b0, 6'd0, 8'h00, 8'h00, 1'b0};

    rst = 1'b1;
    mem_REQ0 = 1'b0; mem_WE0 = 1'b0; mem_A0 = '0; mem_DIN0 = '0;
    init_vld = 1'b0; init_addr = '0; init_data = '0;

    // Reset state, then zero-fill length and clear_done timing.
    idle();
    idle();
    chk("rst_dout", 32'(mem_DOUT0), 32'h0);
    chk("rst_busy", 32'(init_busy), 32'h1);
    chk("rst_clear_done", 32'(clear_done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    release_rst();
    wait_clear(n, early);
    chk("clear_cycles", 32'(n), 32'(DEP));
    chk("clear_done_early", 32'(early), 32'h0);
    chk("clear_done", 32'(clear_done), 32'h1);
    chk("clear_err", 32'(err), 32'h0);
    in_run = 1'b1;

    // Table: backdoor load, RAW, back-to-back reads, blocked backdoor, last address.
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].req, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].iv, vecs[i].ia, vecs[i].id);
      chk($sformatf("vec%0d_dout", i), 32'(mem_DOUT0), 32'(vecs[i].exp_dout));
      chk($sformatf("vec%0d_busy", i), 32'(init_busy), 32'(vecs[i].exp_busy));
    end
    chk("vec_err", 32'(err), 32'h0);

    // Backdoor held while the dut port is busy for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 6'd1, 8'h00, 1'b1, 6'd20, 8'h99);
      chk($sformatf("stall%0d_busy", i), 32'(init_busy), 32'h1);
    end
    step(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 6'd20, 8'h99);
    chk("stall_free_busy", 32'(init_busy), 32'h0);
    step(1'b1, 1'b0, 6'd20, 8'h00, 1'b0, 6'd0, 8'h00);
    idle();
    idle();
    chk("stall_load_dout", 32'(mem_DOUT0), 32'h99);
    chk("stall_err", 32'(err), 32'h0);

    // Out-of-range write and read.
    step(1'b1, 1'b1, 6'd50, 8'hFF, 1'b0, 6'd0, 8'h00);
    step(1'b1, 1'b0, 6'd50, 8'h00, 1'b0, 6'd0, 8'h00);
    chk("oor_err_set", 32'(err), 32'h1);
    step(1'b1, 1'b0, 6'd2, 8'h00, 1'b0, 6'd0, 8'h00);
    idle();
    chk("oor_read_dout", 32'(mem_DOUT0), 32'h0);
    idle();
    chk("oor_alias_dout", 32'(mem_DOUT0), 32'h0);
    idle();
    idle();
    chk("oor_err_sticky", 32'(err), 32'h1);

    // Reset with a read in flight.
    step(1'b1, 1'b1, 6'd5, 8'h66, 1'b0, 6'd0, 8'h00);
    step(1'b1, 1'b0, 6'd5, 8'h00, 1'b0, 6'd0, 8'h00);
    idle();
    idle();
    chk("pre_rst_dout", 32'(mem_DOUT0), 32'h66);
    step(1'b1, 1'b0, 6'd20, 8'h00, 1'b0, 6'd0, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_REQ0 = 1'b0;
    @(negedge clk);
`ifdef MEM_RESP_STATS_EN
    chk("pre_rst_rd_cnt", 32'(rd_cnt), 32'(exp_rd));
    chk("pre_rst_wr_cnt", 32'(wr_cnt), 32'(exp_wr));
`endif
    in_run = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    idle();
    chk("midrst_dout", 32'(mem_DOUT0), 32'h0);
    chk("midrst_err", 32'(err), 32'h0);
    chk("midrst_busy", 32'(init_busy), 32'h1);
    chk("midrst_clear_done", 32'(clear_done), 32'h0);
`ifdef MEM_RESP_STATS_EN
    chk("midrst_rd_cnt", 32'(rd_cnt), 32'h0);
    chk("midrst_wr_cnt", 32'(wr_cnt), 32'h0);
`endif
    release_rst();

    // Read during CLEAR flags an error; refill restarts and wipes old contents.
    step(1'b1, 1'b0, 6'd20, 8'h00, 1'b0, 6'd0, 8'h00);
    idle();
    chk("clear_read_err", 32'(err), 32'h1);
    chk("clear_read_dout", 32'(mem_DOUT0), 32'h0);
    wait_clear(n, early);
    chk("reclear_done", 32'(clear_done), 32'h1);
    in_run = 1'b1;
    step(1'b1, 1'b1, 6'd6, 8'h77, 1'b0, 6'd0, 8'h00);
    step(1'b1, 1'b0, 6'd6, 8'h00, 1'b0, 6'd0, 8'h00);
    step(1'b1, 1'b0, 6'd5, 8'h00, 1'b0, 6'd0, 8'h00);
    idle();
    chk("reclear_new_dout", 32'(mem_DOUT0), 32'h77);
    idle();
    chk("reclear_wiped_dout", 32'(mem_DOUT0), 32'h0);
    chk("reclear_err_sticky", 32'(err), 32'h1);
`ifdef MEM_RESP_STATS_EN
    chk("post_rd_cnt", 32'(rd_cnt), 32'(exp_rd));
    chk("post_wr_cnt", 32'(wr_cnt), 32'(exp_wr));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_resp.md
Name: mem_resp

Overview:
Single-port memory responder, the target end of the explicit-memory interface a synthesized dut drives: REQ0, WE0, A0 and DIN0 come in, DOUT0 goes out.
It holds the storage array, returns read data at a fixed latency, and zero-fills the array after reset.
It also provides a busy/vld backdoor load port so the bench can preload contents.
It sits beside the dut in the verification wrapper and in system-level testbenches.

Parameters:
DATA_W, 8, data width of DIN0/DOUT0 and of the init port
ADDR_W, 6, address width of A0 and of the init port
DEPTH, 64, number of words; legal range 1..2**ADDR_W
RD_LAT, 1, read latency in cycles; legal range 1..4

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
mem_REQ0  input  1  access request from dut
mem_WE0  input  1  1 = write, 0 = read; qualified by mem_REQ0
mem_A0  input  ADDR_W  access address
mem_DIN0  input  DATA_W  write data
mem_DOUT0  output  DATA_W  read data
init_vld  input  1  backdoor write valid
init_busy  output  1  backdoor stall
init_addr  input  ADDR_W  backdoor address
init_data  input  DATA_W  backdoor data
clear_done  output  1  high once zero-fill completes
err  output  1  sticky protocol error flag

Behaviour:
- Single clock clk; reset synchronous, active-high, on rst.
- Reset values: mem_DOUT0=0, init_busy=1, clear_done=0, err=0, read pipeline cleared, FSM=CLEAR, clear pointer=0. Array contents are not reset directly; CLEAR overwrites them.
- FSM CLEAR:
  - Writes 0 to address ptr each cycle, ptr increments, for DEPTH cycles.
  - On the cycle ptr==DEPTH-1 is written, go to RUN.
  - clear_done goes to 1 the cycle after entering RUN.
  - init_busy=1 throughout CLEAR.
  - Any mem_REQ0=1 during CLEAR: set err, drop the access; a read returns 0 at RD_LAT.
- FSM RUN:
  - Write: mem_REQ0=1 and mem_WE0=1 writes mem_DIN0 to mem_A0 at the clock edge.
  - Read: mem_REQ0=1 and mem_WE0=0 returns array[mem_A0] on mem_DOUT0 exactly RD_LAT cycles after the request cycle.
  - Reads are fully pipelined; one may be accepted every cycle.
  - mem_DOUT0 holds the last read result until the next read completes. It is not affected by writes.
  - Read-after-write: a read of an address written in an earlier cycle returns the new data.
  - The dut port cannot be stalled.
- Backdoor port:
  - init_busy = (state==CLEAR) | mem_REQ0 (combinational in RUN). The dut port has priority.
  - A transfer occurs when init_vld=1 and init_busy=0; it writes init_data to init_addr that edge.
- Out of range (address >= DEPTH, dut port or init port):
  - Write is ignored.
  - Read returns 0 at RD_LAT.
  - err is set.
- err is sticky; only rst clears it.
- rst mid-operation: in-flight reads are discarded (mem_DOUT0=0), and CLEAR restarts from ptr 0.
- Back-to-back reads to different addresses produce one result per cycle, in order.

Optional Feature:
MEM_RESP_STATS_EN
- Defined:
  - Adds output ports rd_cnt[15:0] and wr_cnt[15:0].
  - They count dut-port reads and writes accepted in RUN, including out-of-range accesses.
  - Counters saturate at 16'hFFFF and reset to 0 on rst.
  - Backdoor writes and CLEAR writes are not counted.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle, DEPTH=64 -> init_busy=1 for 64 cycles, clear_done=1 on cycle 65, err=0; reading any address then returns 0.
- Backdoor writes 0x5A to addr 3 in RUN, then dut reads addr 3 with RD_LAT=2 -> mem_DOUT0=0x5A exactly 2 cycles after the REQ cycle.
- dut writes 0x11 to addr 7, then reads addr 7 on the next cycle, then reads addr 8 (value 0) back-to-back, RD_LAT=1 -> mem_DOUT0=0x11 then 0x00 on consecutive cycles.
- init_vld=1 held while mem_REQ0=1 for 3 cycles -> init_busy=1 for those 3 cycles; the backdoor write lands on the first cycle mem_REQ0=0.
- DEPTH=48: dut writes addr 50 (value 0xFF), then reads addr 50 -> no write occurs, read returns 0, err=1 and stays 1 until rst; a read during CLEAR also sets err.
- With MEM_RESP_STATS_EN: 5 reads and 3 writes, then rst mid-read -> rd_cnt=5 and wr_cnt=3 before rst; after rst both are 0, mem_DOUT0=0 and CLEAR restarts.
